// File: rtl/async_fifo_pkg.sv
// Shared defaults and helpers for the async FIFO and its read-side packer.
package async_fifo_pkg;

  localparam int DSIZE_DEF   = 8;
  localparam int ASIZE_DEF   = 4;
  localparam int PACK_DEF    = 4;
  localparam int TIMEOUT_DEF = 16;

  // Ceiling log2; callers needing to hold 0..n use clog2(n+1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic [31:0] keep_mask(input int unsigned cnt);
    return (32'd1 << cnt) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// Saturating idle counter; hit_o asserts while the count sits at TIMEOUT.
module fifo_rd_idle_timer
  import async_fifo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int IW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LIMIT = IW'(TIMEOUT);

  logic [IW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (clr_i)                         idle_d = '0;
    else if (inc_i && idle_q != LIMIT) idle_d = idle_q + IW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign hit_o = (TIMEOUT != 0) && (idle_q == LIMIT);

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the async FIFO read port and packs PACK words per valid/ready beat;
// partial beats leave on flush or idle timeout with a contiguous keep mask.
module fifo_rd_packer
  import async_fifo_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int PACK    = PACK_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic                    rempty,
  input  logic [DSIZE-1:0]        rdata,
  output logic                    rreq,
  input  logic                    flush,
  output logic [PACK*DSIZE-1:0]   m_data,
  output logic [PACK-1:0]         m_keep,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy
);

  localparam int CW = clog2(PACK + 1);
  localparam logic [CW-1:0] FULL = CW'(PACK);

  logic [PACK-1:0][DSIZE-1:0] lanes_q, lanes_d;
  logic [CW-1:0]              cnt_q, cnt_d, wr_idx;
  logic                       flush_pend_q, flush_pend_d;
  logic [PACK*DSIZE-1:0]      m_data_q, m_data_d, beat_data;
  logic [PACK-1:0]            m_keep_q, m_keep_d;
  logic                       m_valid_q, m_valid_d;
  logic                       cnt_nz, out_free, emit, pop, tmo_hit;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cnt_nz   = (cnt_q != '0);
    out_free = ~m_valid_q | m_ready;
    emit     = out_free & cnt_nz & ((cnt_q == FULL) | flush_pend_q | flush | tmo_hit);
    rreq     = ~rempty & ((cnt_q < FULL) | emit);
    pop      = rreq & ~rempty;
    // A pop that coincides with an emit starts the next beat at lane 0.
    wr_idx   = emit ? '0 : cnt_q;

    for (int i = 0; i < PACK; i++)
      beat_data[i*DSIZE +: DSIZE] = (CW'(i) < cnt_q) ? lanes_q[i] : '0;

    lanes_d      = lanes_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_valid_d    = m_valid_q;

    if (emit) begin
      m_data_d     = beat_data;
      m_keep_d     = PACK'(keep_mask(32'(cnt_q)));
      m_valid_d    = 1'b1;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (m_ready)        m_valid_d    = 1'b0;
      if (flush & cnt_nz) flush_pend_d = 1'b1;
    end

    if (pop) begin
      for (int i = 0; i < PACK; i++)
        if (CW'(i) == wr_idx) lanes_d[i] = rdata;
      cnt_d = wr_idx + CW'(1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      // NOTE: lane registers are reset too, so a mid-beat reset leaves no
      // stale word that a later beat could expose.
      lanes_q      <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_valid_q    <= 1'b0;
    end else begin
      lanes_q      <= lanes_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
    end
  end

  fifo_rd_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk   (rclk),
    .rst_n (rrst_n),
    .clr_i (pop | emit),
    .inc_i (cnt_nz),
    .hit_o (tmo_hit)
  );

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_valid = m_valid_q;
  assign busy    = cnt_nz | m_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue models the FIFO read port.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rrst_n, rempty, rreq, flush, m_valid, m_ready, busy;
  logic [7:0]  rdata;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } beat_t;

  beat_t      beats[$];
  logic [7:0] fifo_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pops   = 0;

  fifo_rd_packer #(.DSIZE(8), .PACK(4), .TIMEOUT(16)) dut (
    .rclk    (clk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rreq    (rreq),
    .flush   (flush),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    sync_fifo();
  endtask

  // One clock: called at a negedge, samples handshakes just before the
  // posedge, applies the pop to the FIFO model, returns at the next negedge.
  task automatic cyc();
    logic  p;
    beat_t b;
    #4;
    p = rreq && !rempty;
    if (m_valid && m_ready) begin
      b.data = m_data;
      b.keep = m_keep;
      beats.push_back(b);
    end
    @(posedge clk);
    if (p) begin
      void'(fifo_q.pop_front());
      n_pops++;
    end
    @(negedge clk);
    flush = 1'b0;
    sync_fifo();
  endtask

  initial begin
    int highs;
    rrst_n  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    sync_fifo();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_keep",  m_keep,  0);
    chk("rst_m_data",  m_data,  0);
    chk("rst_busy",    busy,    0);
    chk("rst_rreq_empty", rreq, 0);
    rempty = 1'b0;
    #1 chk("rst_rreq_nonempty", rreq, 1);
    sync_fifo();
    @(negedge clk);
    rrst_n = 1'b1;

    // Two full beats back to back.
    for (int i = 1; i <= 8; i++) push(8'(i));
    n_pops = 0;
    repeat (4) cyc();
    chk("full_pops4", n_pops, 4);
    chk("full_no_valid_yet", m_valid, 0);
    cyc();
    chk("full_b0_valid", m_valid, 1);
    chk("full_b0_data", m_data, 32'h04030201);
    chk("full_b0_keep", m_keep, 4'hF);
    repeat (3) cyc();
    chk("full_pops8", n_pops, 8);
    cyc();
    chk("full_b1_data", m_data, 32'h08070605);
    chk("full_b1_keep", m_keep, 4'hF);
    cyc();
    chk("full_drained_valid", m_valid, 0);
    chk("full_drained_busy", busy, 0);

    // Partial beat via idle timeout.
    push(8'hA0); push(8'hA1); push(8'hA2);
    repeat (19) cyc();
    chk("tmo_not_yet", m_valid, 0);
    chk("tmo_busy_partial", busy, 1);
    cyc();
    chk("tmo_valid", m_valid, 1);
    chk("tmo_data", m_data, 32'h00A2A1A0);
    chk("tmo_keep", m_keep, 4'h7);
    cyc();
    chk("tmo_accept_busy", busy, 0);

    // Flush coinciding with a pop.
    push(8'hB0); push(8'hB1); push(8'hB2);
    cyc(); cyc();
    flush = 1'b1;
    cyc();
    chk("flsh_data", m_data, 32'h0000B1B0);
    chk("flsh_keep", m_keep, 4'h3);
    flush = 1'b1;
    cyc();
    chk("flsh_next_data", m_data, 32'h000000B2);
    chk("flsh_next_keep", m_keep, 4'h1);
    cyc();
    chk("flsh_busy", busy, 0);

    // Backpressure over a 12-word stream.
    beats.delete();
    n_pops  = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'hC0 + 8'(i));
    repeat (5) cyc();
    chk("bp_first_data", m_data, 32'hC3C2C1C0);
    repeat (5) cyc();
    chk("bp_held_data", m_data, 32'hC3C2C1C0);
    chk("bp_held_valid", m_valid, 1);
    chk("bp_rreq_low", rreq, 0);
    chk("bp_pops_held", n_pops, 8);
    m_ready = 1'b1;
    repeat (6) cyc();
    chk("bp_pops_total", n_pops, 12);
    chk("bp_nbeats", beats.size(), 3);
    chk("bp_beat0", beats[0], {32'hC3C2C1C0, 4'hF});
    chk("bp_beat1", beats[1], {32'hC7C6C5C4, 4'hF});
    chk("bp_beat2", beats[2], {32'hCBCAC9C8, 4'hF});
    chk("bp_busy", busy, 0);

    // Flush on an empty accumulator is ignored.
    flush = 1'b1;
    cyc();
    chk("flush_empty_valid", m_valid, 0);
    cyc();
    chk("flush_empty_valid2", m_valid, 0);
    chk("flush_empty_busy", busy, 0);

    // Flush while stalled with two words held is remembered.
    beats.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
    repeat (6) cyc();
    flush = 1'b1;
    cyc();
    cyc();
    chk("pend_held_data", m_data, 32'hD3D2D1D0);
    chk("pend_held_valid", m_valid, 1);
    m_ready = 1'b1;
    cyc();
    chk("pend_data", m_data, 32'h0000D5D4);
    chk("pend_keep", m_keep, 4'h3);
    cyc();
    chk("pend_nbeats", beats.size(), 2);
    chk("pend_beat1", beats[1], {32'h0000D5D4, 4'h3});
    chk("pend_busy", busy, 0);

    // Asynchronous reset with a partial beat and a held output.
    beats.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(8'hE0 + 8'(i));
    repeat (7) cyc();
    chk("rst2_pre_valid", m_valid, 1);
    rrst_n = 1'b0;
    #1;
    chk("rst2_valid", m_valid, 0);
    chk("rst2_keep",  m_keep,  0);
    chk("rst2_data",  m_data,  0);
    chk("rst2_busy",  busy,    0);
    @(negedge clk);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    highs   = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (m_valid) highs++;
    end
    chk("rst2_no_stale_valid", highs, 0);
    chk("rst2_no_beats", beats.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
